// File: rtl/rst_seq_if.sv
// Handshake bundle for rst_seq_module: software re-sequence request, per-stage
// acknowledges, and the staged reset / status outputs.
`timescale 1ns/1ps
interface rst_seq_if #(
   parameter int P_STAGES = 4
);
   logic                i_req_rst;
   logic [P_STAGES-1:0] i_ack;
   logic [P_STAGES-1:0] o_rst;
   logic                o_done;
   logic                o_err;
   logic [2:0]          o_err_stage;

   modport master (
      output i_req_rst, i_ack,
      input  o_rst, o_done, o_err, o_err_stage
   );

   modport slave (
      input  i_req_rst, i_ack,
      output o_rst, o_done, o_err, o_err_stage
   );
endinterface

// File: rtl/rst_seq_module.sv
// Staged reset sequencer: releases per-domain resets in index order with a gap.
// Macro RST_SEQ_ACK_EN adds per-stage acknowledge wait with timeout error.
`timescale 1ns/1ps
module rst_seq_module #(
   parameter int P_STAGES    = 4,
   parameter int P_GAP_CYCLE = 16,
   parameter int P_TIMEOUT   = 1024
) (
   input  logic     i_clk,
   input  logic     i_rst,
   rst_seq_if.slave bus
);
   typedef enum logic [1:0] {S_GAP, S_WAIT, S_DONE, S_ERR} state_t;

   localparam logic [2:0]  LP_LAST     = 3'(P_STAGES - 1);
   localparam logic [15:0] LP_GAP_LAST = 16'(P_GAP_CYCLE - 1);

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_k, w_k_nxt;
   logic [15:0]         r_cnt, w_cnt_nxt;
   logic [P_STAGES-1:0] r_rst, w_rst_nxt;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic [2:0]          r_err_stage, w_err_stage_nxt;
   logic [P_STAGES-1:0] w_k_onehot;

   always_comb begin
      w_k_onehot = '0;
      for (int i = 0; i < P_STAGES; i++) begin
         if (r_k == 3'(i)) w_k_onehot[i] = 1'b1;
      end
   end

`ifdef RST_SEQ_ACK_EN
   localparam logic [15:0] LP_TO_LAST = 16'(P_TIMEOUT - 1);
   logic w_ack_cur;
   // Only the acknowledge of the stage currently being waited on matters.
   assign w_ack_cur = |(bus.i_ack & w_k_onehot);
`else
   logic w_unused_ack;
   assign w_unused_ack = |bus.i_ack;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_k_nxt         = r_k;
      w_cnt_nxt       = r_cnt;
      w_rst_nxt       = r_rst;
      w_done_nxt      = r_done;
      w_err_nxt       = r_err;
      w_err_stage_nxt = r_err_stage;
      if (bus.i_req_rst) begin
         w_state_nxt     = S_GAP;
         w_k_nxt         = '0;
         w_cnt_nxt       = '0;
         w_rst_nxt       = '1;
         w_done_nxt      = 1'b0;
         w_err_nxt       = 1'b0;
         w_err_stage_nxt = '0;
      end else begin
         case (r_state)
            S_GAP: begin
               if (r_cnt == LP_GAP_LAST) begin
                  w_rst_nxt = r_rst & ~w_k_onehot;
                  w_cnt_nxt = '0;
`ifdef RST_SEQ_ACK_EN
                  w_state_nxt = S_WAIT;
`else
                  if (r_k == LP_LAST) w_state_nxt = S_DONE;
                  else                w_k_nxt     = r_k + 3'd1;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
`ifdef RST_SEQ_ACK_EN
            S_WAIT: begin
               if (w_ack_cur) begin
                  if (r_k == LP_LAST) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_k_nxt     = r_k + 3'd1;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_GAP;
                  end
               end else if (r_cnt == LP_TO_LAST) begin
                  w_state_nxt     = S_ERR;
                  w_err_nxt       = 1'b1;
                  w_err_stage_nxt = r_k;
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
            S_ERR: begin
               w_state_nxt = S_ERR;
            end
`endif
            // Without acknowledge checking, done rises one edge after the last release.
            S_DONE: begin
               w_done_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_GAP;
         r_k         <= '0;
         r_cnt       <= '0;
         r_rst       <= '1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_stage <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_k         <= w_k_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rst       <= w_rst_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_err_stage <= w_err_stage_nxt;
      end
   end

   assign bus.o_rst       = r_rst;
   assign bus.o_done      = r_done;
   assign bus.o_err       = r_err;
   assign bus.o_err_stage = r_err_stage;
endmodule

// File: tb/tb_rst_seq_module.sv
// Scoreboard bench for rst_seq_module: every expected output change is queued
// with its edge number; monitors pop and compare on each observed change.
`timescale 1ns/1ps
module tb_rst_seq_module;
   localparam int NS = 3;
`ifdef RST_SEQ_ACK_EN
   localparam int D1 = 9;
   localparam int D2 = 14;
   localparam int DD = 15;
`else
   localparam int D1 = 8;
   localparam int D2 = 12;
   localparam int DD = 13;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] v;
   } ev_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    rst_b = 1'b1;
   int      cyc = 0;
   int      n_cmp = 0;
   int      n_bad = 0;
   ev_t     qa[$];
   ev_t     qb[$];
   logic [NS-1:0] ack_mask = 3'b111;
   logic [NS-1:0] ack_force = 3'b000;
`ifdef RST_SEQ_ACK_EN
   logic    ack_follow = 1'b1;
`else
   logic    ack_follow = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rst_seq_if #(.P_STAGES(3)) ifa ();
   rst_seq_if #(.P_STAGES(1)) ifb ();

   assign ifa.i_ack     = ack_follow ? (~ifa.o_rst & ack_mask) : ack_force;
   assign ifb.i_ack     = 1'b1;
   assign ifb.i_req_rst = 1'b0;

   rst_seq_module #(.P_STAGES(3), .P_GAP_CYCLE(4), .P_TIMEOUT(8)) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifa.slave)
   );

   rst_seq_module #(.P_STAGES(1), .P_GAP_CYCLE(1), .P_TIMEOUT(8)) dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (ifb.slave)
   );

   function automatic ev_t mk(int c, logic [7:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      return e;
   endfunction

   task automatic cmp_ev(string nm, ev_t e, logic [7:0] cur);
      n_cmp += 2;
      if (cur !== e.v) begin
         n_bad++;
         $display("FAIL %s value at edge %0d: got %b expected %b", nm, cyc, cur, e.v);
      end
      if (cyc != e.cyc) begin
         n_bad++;
         $display("FAIL %s timing for %b: seen at edge %0d expected edge %0d", nm, e.v, cyc, e.cyc);
      end
   endtask

   task automatic extra_ev(string nm, logic [7:0] cur);
      n_cmp++;
      n_bad++;
      $display("FAIL %s unexpected change at edge %0d: got %b expected no change", nm, cyc, cur);
   endtask

   // Monitors: {o_rst, o_done, o_err, o_err_stage}, padded to 8 bits for dut_b.
   logic [7:0] prev_a = 'x;
   logic [7:0] prev_b = 'x;
   always @(negedge clk) begin
      logic [7:0] cur;
      cur = {ifa.o_rst, ifa.o_done, ifa.o_err, ifa.o_err_stage};
      if (cur !== prev_a) begin
         if (qa.size() == 0) extra_ev("A", cur);
         else                cmp_ev("A", qa.pop_front(), cur);
         prev_a = cur;
      end
   end
   always @(negedge clk) begin
      logic [7:0] cur;
      cur = {2'b00, ifb.o_rst, ifb.o_done, ifb.o_err, ifb.o_err_stage};
      if (cur !== prev_b) begin
         if (qb.size() == 0) extra_ev("B", cur);
         else                cmp_ev("B", qb.pop_front(), cur);
         prev_b = cur;
      end
   end

   task automatic at_edge(int n);
      while (cyc < n - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(int n, bit do_rst, bit do_req);
      at_edge(n);
      if (do_rst) rst = 1'b1;
      if (do_req) ifa.i_req_rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifa.i_req_rst = 1'b0;
   endtask

   task automatic push_rst(int e);
      qa.push_back(mk(e, 8'b111_0_0_000));
   endtask

   task automatic push_seq(int e);
      qa.push_back(mk(e + 4,  8'b110_0_0_000));
      qa.push_back(mk(e + D1, 8'b100_0_0_000));
      qa.push_back(mk(e + D2, 8'b000_0_0_000));
      qa.push_back(mk(e + DD, 8'b000_1_0_000));
   endtask

   task automatic direct(string nm, logic [7:0] got, logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, got, exp);
      end
   endtask

   initial begin
      ifa.i_req_rst = 1'b0;
      // Power-on: both DUTs reset at edge 1.
      push_rst(1);
      push_seq(1);
      qb.push_back(mk(1, 8'b00_1_0_0_000));
      qb.push_back(mk(2, 8'b00_0_0_0_000));
      qb.push_back(mk(3, 8'b00_0_1_0_000));
      @(posedge clk);
      #1;
      rst   = 1'b0;
      rst_b = 1'b0;

      // Software re-sequence from DONE.
      push_rst(30);
      push_seq(30);
      pulse(30, 1'b0, 1'b1);

      // Single-stage instance, second reset.
      qb.push_back(mk(40, 8'b00_1_0_0_000));
      qb.push_back(mk(41, 8'b00_0_0_0_000));
      qb.push_back(mk(42, 8'b00_0_1_0_000));
      at_edge(40);
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      rst_b = 1'b0;

`ifdef RST_SEQ_ACK_EN
      // Stage-1 acknowledge withheld: timeout into sticky ERR.
      ack_mask = 3'b101;
      push_rst(50);
      qa.push_back(mk(54, 8'b110_0_0_000));
      qa.push_back(mk(59, 8'b100_0_0_000));
      qa.push_back(mk(67, 8'b100_0_1_001));
      pulse(50, 1'b1, 1'b0);
      at_edge(90);
      direct("err_hold", {ifa.o_rst, ifa.o_done, ifa.o_err, ifa.o_err_stage}, 8'b100_0_1_001);
      ack_mask = 3'b111;
`else
      // Acks asserted but ignored: timing unchanged.
      ack_force = 3'b111;
      push_rst(50);
      push_seq(50);
      pulse(50, 1'b1, 1'b0);
      at_edge(90);
      direct("done_ack_ignored", {ifa.o_rst, ifa.o_done, ifa.o_err, ifa.o_err_stage}, 8'b000_1_0_000);
      ack_force = 3'b000;
`endif
      // Re-sequence request (clears ERR in the acknowledge build).
      push_rst(92);
      push_seq(92);
      pulse(92, 1'b0, 1'b1);

      // Reset mid-sequence while o_rst=100.
      push_rst(120);
      qa.push_back(mk(124,      8'b110_0_0_000));
      qa.push_back(mk(120 + D1, 8'b100_0_0_000));
      push_rst(130);
      push_seq(130);
      pulse(120, 1'b1, 1'b0);
      pulse(130, 1'b1, 1'b0);

      // Simultaneous reset and request mid-sequence.
      push_rst(160);
      qa.push_back(mk(164,      8'b110_0_0_000));
      qa.push_back(mk(160 + D1, 8'b100_0_0_000));
      push_rst(170);
      push_seq(170);
      pulse(160, 1'b1, 1'b0);
      pulse(170, 1'b1, 1'b1);

      at_edge(200);
      @(negedge clk);
      direct("final_a", {ifa.o_rst, ifa.o_done, ifa.o_err, ifa.o_err_stage}, 8'b000_1_0_000);
      direct("final_b", {2'b00, ifb.o_rst, ifb.o_done, ifb.o_err, ifb.o_err_stage}, 8'b00_0_1_0_000);
      foreach (qa[i]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL A missing event: got none expected %b at edge %0d", qa[i].v, qa[i].cyc);
      end
      foreach (qb[i]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL B missing event: got none expected %b at edge %0d", qb[i].v, qb[i].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rst_seq_module.md
# rst_seq_module

Staged reset sequencer directly downstream of the power-on reset generator. Its `i_rst` is driven by the generator's held reset. It releases up to 8 per-domain resets one at a time, in index order, with a programmable gap between releases. When acknowledge checking is compiled in, each stage must acknowledge before the next stage is released, and a stage that never acknowledges raises a timeout error.

## Interface
- `P_STAGES`, default 4: number of reset outputs; legal range 1..8.
- `P_GAP_CYCLE`, default 16: clock cycles from stage entry to release of the next stage; legal range 1..65535.
- `P_TIMEOUT`, default 1024: cycles to wait for an acknowledge before flagging an error; legal range 1..65535.
- `i_clk` input 1: single clock for the whole block.
- `i_rst` input 1: reset, synchronous, active-high; driven from the reset generator output.
- `i_req_rst` input 1: single-cycle software request to re-run the whole sequence.
- `i_ack` input P_STAGES: stage k ready; level-sensitive, sampled only while waiting on stage k.
- `o_rst` output P_STAGES: per-stage reset, active-high.
- `o_done` output 1: high once every stage is released and acknowledged.
- `o_err` output 1: acknowledge timeout occurred.
- `o_err_stage` output 3: index of the stage that timed out.

## Operation
- States:
  - GAP: count `P_GAP_CYCLE`, then release the current stage.
  - WAIT: wait for `i_ack` of the current stage, or time out.
  - DONE: all stages released.
  - ERR: timeout occurred; sticky.
- Stage index `k` is 3 bits. One shared 16-bit counter serves both the gap count and the timeout count.
- Reset (`i_rst`=1 at an edge) sets:
  - `o_rst` all ones; `o_done`=0, `o_err`=0, `o_err_stage`=0.
  - state GAP, k=0, cnt=0.
- GAP behaviour:
  - cnt increments each edge.
  - At the edge where cnt==`P_GAP_CYCLE`-1: `o_rst[k]`<=0, cnt<=0, state -> WAIT.
- WAIT behaviour:
  - If `i_ack[k]`=1 at an edge and k is the last stage (`P_STAGES`-1): state -> DONE, `o_done`<=1.
  - If `i_ack[k]`=1 at an edge and k is not last: k<=k+1, cnt<=0, state -> GAP.
  - Otherwise, if cnt==`P_TIMEOUT`-1: state -> ERR, `o_err`<=1, `o_err_stage`<=k.
  - Otherwise: cnt increments.
- ERR holds all outputs: stages below k stay released, stage k is released but unacknowledged, stages above k stay in reset. ERR exits only via `i_rst` or `i_req_rst`.
- `i_req_rst`=1 at an edge, from any state: same effect as `i_rst`, i.e. the full sequence restarts.
- Priority: `i_rst` over `i_req_rst` over everything else. Simultaneous `i_rst` and `i_req_rst` is a plain reset.
- Acknowledges of already-released stages are ignored. Dropping such an ack later has no effect.
- An `i_ack[k]` already high on entry to WAIT is accepted at the first WAIT edge.
- `o_rst` is driven directly from registers, with no combinational path from any input.

## Timing
- Let E be the last edge sampling `i_rst`=1 (or `i_req_rst`=1).
- `o_rst[0]` falls at E+`P_GAP_CYCLE`.
- With acknowledge checking, an ack sampled at edge A makes `o_rst[k+1]` fall at A+`P_GAP_CYCLE`.
- `o_done` rises on the edge that samples the last ack.
- Timeout: WAIT entered at edge W with no ack gives `o_err`=1 at W+`P_TIMEOUT`.

## Configuration
- Macro `RST_SEQ_ACK_EN`.
- Defined:
  - WAIT state and timeout logic are present, as described above.
- Undefined:
  - `i_ack` is ignored and WAIT/ERR are not built.
  - Releasing stage k at edge X goes straight to GAP for k+1 with cnt=0, so the next release is at X+`P_GAP_CYCLE`.
  - After the last release, state -> DONE and `o_done` rises one edge later.
  - `o_err` and `o_err_stage` are constant 0.

## Test plan
All scenarios use `P_STAGES`=3, `P_GAP_CYCLE`=4, `P_TIMEOUT`=8; scenarios 1-4 have `RST_SEQ_ACK_EN` defined.
1. Normal sequence: `i_rst` last high at E, `i_ack`=~`o_rst` -> `o_rst` 111->110 at E+4, ->100 at E+9, ->000 at E+14; `o_done`=1 at E+15; `o_err` stays 0.
2. Stage-1 timeout: `i_ack[1]` held 0, other acks as in scenario 1 -> `o_rst[1]` falls at E+9; `o_err`=1 and `o_err_stage`=1 at E+17; `o_rst`=100 held indefinitely; `o_done`=0.
3. Software re-sequence: `i_req_rst` pulse sampled at edge R while in DONE -> `o_rst`=111 and `o_done`=0 at R; sequence repeats with scenario-1 timing relative to R. The same pulse while in ERR clears `o_err`.
4. Reset mid-sequence: `i_rst` asserted at edge E+10 (`o_rst`=100) -> all ones at E+10. Simultaneous `i_rst`+`i_req_rst` gives identical behaviour.
5. Macro undefined, acks tied 0 -> `o_rst` falls per stage at E+4, E+8, E+12; `o_done` at E+13; `o_err` never asserts.
6. `P_STAGES`=1, `P_GAP_CYCLE`=1, ack high -> `o_rst` falls at E+1; `o_done` at E+2.
